// File: rtl/pipe_fcu.sv
// pipe_fcu: fetch control unit, single-outstanding imem fetch with a skid buffer feeding the IF/ID stage.
module pipe_fcu #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            jmp_i,
   input  logic [XLEN-1:0] jmp_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            inst_valid_o,
   output logic [31:0]     inst_data_o,
   output logic [XLEN-1:0] pc_data_o,
   output logic [XLEN-1:0] pc_next_o
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, skid_pc_q;
   logic [31:0]     skid_inst_q;
   logic            kill_q, free, consume, rsp, load, skid_load, from_skid;
   assign free      = ~inst_valid_o | ~stall_i;
   assign consume   = inst_valid_o & ~stall_i;
   assign rsp       = (state_q == S_WAIT) & imem_rvalid_i;
   assign load      = rsp & ~kill_q & free;
   assign skid_load = rsp & ~kill_q & ~free;
   assign from_skid = (state_q == S_HOLD) & free;
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   state_d = imem_gnt_i ? S_WAIT : S_REQ;
         S_WAIT:  state_d = !imem_rvalid_i ? S_WAIT : (jmp_i || kill_q || free) ? S_REQ : S_HOLD;
         S_HOLD:  state_d = (jmp_i || free) ? S_REQ : S_HOLD;
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      imem_req_o  = state_q == S_REQ;
      imem_addr_o = pc_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q         <= RESET_PC;
         kill_q       <= 1'b0;
         inst_valid_o <= 1'b0;
         inst_data_o  <= '0;
         pc_data_o    <= '0;
         pc_next_o    <= '0;
         skid_inst_q  <= '0;
         skid_pc_q    <= '0;
      end else if (jmp_i) begin
         // an old-address fetch still in flight must be discarded when it returns
         inst_valid_o <= 1'b0;
         pc_q         <= jmp_pc_i & ~XLEN'(3);
         kill_q       <= (state_q == S_REQ && imem_gnt_i) || (state_q == S_WAIT && !imem_rvalid_i);
      end else begin
         if (rsp) kill_q <= 1'b0;
         if (rsp && !kill_q) pc_q <= pc_q + XLEN'(4);
         if (load) begin
            inst_valid_o <= 1'b1;
            inst_data_o  <= imem_rdata_i;
            pc_data_o    <= pc_q;
            pc_next_o    <= pc_q + XLEN'(4);
         end else if (from_skid) begin
            inst_valid_o <= 1'b1;
            inst_data_o  <= skid_inst_q;
            pc_data_o    <= skid_pc_q;
            pc_next_o    <= skid_pc_q + XLEN'(4);
         end else if (consume) begin
            inst_valid_o <= 1'b0;
         end
         if (skid_load) begin
            skid_inst_q <= imem_rdata_i;
            skid_pc_q   <= pc_q;
         end
      end
   end
endmodule
